av2_coeff_decoder: RTL and testbench
====================================

Name: av2_coeff_decoder

Overview:
- Converts entropy-decoded symbols into dequantized transform coefficients for one square transform block.
- Sits between the entropy decoder (symbol stream) and the coefficient store that feeds the inverse transform in the tile decoder.
- Emits every coefficient of the block, one per handshake, with its raster address, then reports the end-of-block count.

Parameters:
- MAX_TX, 64, maximum transform width; the coefficient address space is 4096.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- context_idx  in  16  reserved; ignored
- context_prob  in  16  reserved; ignored
- decoded_symbol  in  16  symbol from the entropy decoder
- symbol_valid  in  1  decoded_symbol is valid
- symbol_ready  out  1  block accepts a symbol this cycle
- coeff_out  out  16  signed dequantized coefficient
- coeff_addr  out  12  coefficient address in the block
- coeff_valid  out  1  coeff_out/coeff_addr valid
- coeff_ready  in  1  downstream accepts the coefficient
- num_coeffs  out  16  end-of-block (EOB) count of the last block
- coeffs_valid  out  1  block summary valid
- coeffs_ready  in  1  summary accepted
- tx_size  in  6  transform width w (square block)
- tx_type  in  4  0 = raster scan; nonzero = transposed scan
- qindex  in  8  quantizer index
- start  in  1  begin a block (level-sampled in IDLE)
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset clears all outputs and registers to 0, state to IDLE, and aborts any block in progress.
- States: IDLE, READ_EOB, READ_LEVEL, EMIT, REPORT, DONE.
- IDLE:
  - On start=1, latch w = max(tx_size, 4), tx_type and dq = qindex + 4 (9-bit unsigned).
  - N = w*w; go to READ_EOB.
  - start is ignored in every other state.
- READ_EOB:
  - symbol_ready=1.
  - On symbol_valid&&symbol_ready, eob = min(unsigned decoded_symbol, N); set k=0.
  - Go to READ_LEVEL if eob>0, else to EMIT with a zero coefficient.
- READ_LEVEL:
  - symbol_ready=1.
  - On a handshake, level = signed decoded_symbol.
  - product = level*dq as a 25-bit signed value, saturated to [-32768, 32767], is loaded into coeff_out.
  - Go to EMIT.
- EMIT:
  - coeff_valid=1 and symbol_ready=0.
  - coeff_out and coeff_addr are held stable until coeff_ready=1 at a clock edge (the consumer may take several cycles).
  - coeff_addr = k when tx_type==0, else (k mod w)*w + k/w.
  - On acceptance: k++.
    - If k<eob: go to READ_LEVEL.
    - Else if k<N: stay in EMIT with coeff_out=0 at the next address.
    - Else: go to REPORT.
  - Every block produces exactly N coefficient handshakes, covering all addresses 0..N-1 exactly once.
- REPORT:
  - coeffs_valid=1 and num_coeffs=eob.
  - On coeffs_ready=1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; coeffs_valid=0; return to IDLE.
  - If start is still high in IDLE on the following cycle, a new block starts.
- num_coeffs holds its value until the next READ_EOB update.
- Outputs are registered: coeff_valid asserts the cycle after the level handshake.
- Symbols presented while symbol_ready=0 are not consumed. symbol_ready is combinational from state only, with no dependency on symbol_valid.
- An eob symbol > N is clamped to N; no error flag.
- Reset mid-block: all outputs are 0 on the next cycle and all counts are discarded.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-EMIT.
  - Response: coeff_valid, done, coeffs_valid, symbol_ready and num_coeffs are all 0 immediately; IDLE after release.
- 4x4 raster block:
  - Stimulus: tx_size=4, tx_type=0, qindex=0; symbols 3, 1, -2, 5; coeff_ready tied 1.
  - Response: 16 coefficients with addr0=4, addr1=-8, addr2=20, addrs 3..15=0; num_coeffs=3; done one pulse.
- Transposed scan:
  - Stimulus: tx_size=4, tx_type=1, eob=2, levels 7, 9, qindex=4 (dq=8).
  - Response: addr0=56, addr4=72, all others 0.
- Saturation:
  - Stimulus: qindex=255 (dq=259), level 32767 then -32768.
  - Response: coeff_out=32767, then -32768.
- Backpressure:
  - Stimulus: coeff_ready asserted one cycle after coeff_valid, as a registered consumer would do.
  - Response: each coefficient is held for 2 cycles, no duplicates or losses; symbol_ready=0 during EMIT.
- EOB edge cases:
  - Stimulus: eob=0 with tx_size=8.
  - Response: 64 zeros emitted, num_coeffs=0.
  - Stimulus: eob=100 with tx_size=4.
  - Response: clamped so exactly 16 levels are consumed, num_coeffs=16.

Source files
------------

// File: rtl/av2_coeff_decoder.sv
// av2_coeff_decoder
// Turns the entropy-decoded symbol stream of one square transform block into
// dequantized coefficients. The first symbol of a block is the end-of-block
// (EOB) count; the next EOB symbols are signed levels. Every one of the N = w*w
// positions is emitted once (levels first, then zero fill) with its raster
// address. The block closes with an EOB summary and a one-cycle done pulse.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. A producer holds its payload stable while valid=1 and ready=0.
// symbol_ready depends on the state register only, never on symbol_valid.
module av2_coeff_decoder #(
    parameter int MAX_TX = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        context_idx,
    input  logic [15:0]        context_prob,
    input  logic [15:0]        decoded_symbol,
    input  logic               symbol_valid,
    output logic               symbol_ready,
    output logic signed [15:0] coeff_out,
    output logic [11:0]        coeff_addr,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [15:0]        num_coeffs,
    output logic               coeffs_valid,
    input  logic               coeffs_ready,
    input  logic [5:0]         tx_size,
    input  logic [3:0]         tx_type,
    input  logic [7:0]         qindex,
    input  logic               start,
    output logic               done,
    output logic [2:0]         o_dbg_state
);

    // Address width covers MAX_TX*MAX_TX positions; counts need one more bit
    // so that k can reach N itself.
    localparam int AW = $clog2(MAX_TX * MAX_TX);
    localparam int NW = AW + 1;
    localparam int WW = $clog2(MAX_TX);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ_EOB   = 3'd1,
        S_READ_LEVEL = 3'd2,
        S_EMIT       = 3'd3,
        S_REPORT     = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t             r_state;

    // Block configuration latched at start.
    logic [WW-1:0]      r_w;
    logic               r_transposed;
    logic [8:0]         r_dq;
    logic [NW-1:0]      r_n;
    logic [NW-1:0]      r_eob;

    // Scan position: k is the emission index, (r_row, r_col) = (k / w, k mod w)
    // and r_taddr = r_col * w + r_row is the transposed address of k, all
    // stepped incrementally so no divider or extra multiplier is needed.
    logic [NW-1:0]      r_k;
    logic [WW-1:0]      r_col;
    logic [WW-1:0]      r_row;
    logic [AW-1:0]      r_taddr;

    // Registered outputs.
    logic signed [15:0] r_coeff_out;
    logic [AW-1:0]      r_coeff_addr;
    logic               r_coeff_valid;
    logic [15:0]        r_num_coeffs;
    logic               r_coeffs_valid;
    logic               r_done;

    // Context inputs are reserved for a later revision of the entropy path.
    logic               w_unused_ctx;
    assign w_unused_ctx = ^{context_idx, context_prob};

    // Start-time configuration: transform width floors at 4.
    logic [WW-1:0]      w_w_in;
    logic [NW-1:0]      w_n_in;
    assign w_w_in = (tx_size < WW'(4)) ? WW'(4) : tx_size;
    assign w_n_in = {{(NW-WW){1'b0}}, w_w_in} * {{(NW-WW){1'b0}}, w_w_in};

    // EOB symbol is clamped to the block size.
    logic [NW-1:0]      w_eob_in;
    assign w_eob_in = (decoded_symbol > {{(16-NW){1'b0}}, r_n}) ? r_n
                                                                  : decoded_symbol[NW-1:0];

    // Dequantization: signed level times unsigned dq, saturated to 16 bits.
    // |level*dq| < 2^24, so 25 bits hold the exact product.
    logic signed [24:0] w_lvl_ext;
    logic signed [24:0] w_dq_ext;
    logic signed [24:0] w_prod;
    logic signed [15:0] w_sat;
    assign w_lvl_ext = {{9{decoded_symbol[15]}}, decoded_symbol};
    assign w_dq_ext  = {16'd0, r_dq};
    assign w_prod    = w_lvl_ext * w_dq_ext;
    assign w_sat     = (w_prod > 25'sd32767)  ? 16'sh7FFF :
                       (w_prod < -25'sd32768) ? 16'sh8000 :
                                                w_prod[15:0];

    // Next scan position after the current coefficient is accepted.
    logic [NW-1:0]      w_k_nxt;
    logic [WW-1:0]      w_col_nxt;
    logic [WW-1:0]      w_row_nxt;
    logic [AW-1:0]      w_taddr_nxt;
    logic [AW-1:0]      w_addr_nxt;

    // Step the row/column walk; a column wrap starts the next transposed column.
    always_comb begin
        w_k_nxt     = r_k + NW'(1);
        w_col_nxt   = r_col + WW'(1);
        w_row_nxt   = r_row;
        w_taddr_nxt = r_taddr + {{(AW-WW){1'b0}}, r_w};
        if (r_col == r_w - WW'(1)) begin
            w_col_nxt   = '0;
            w_row_nxt   = r_row + WW'(1);
            w_taddr_nxt = {{(AW-WW){1'b0}}, r_row + WW'(1)};
        end
        w_addr_nxt = r_transposed ? w_taddr_nxt : w_k_nxt[AW-1:0];
    end

    // Block FSM with all outputs registered; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_w            <= '0;
            r_transposed   <= 1'b0;
            r_dq           <= '0;
            r_n            <= '0;
            r_eob          <= '0;
            r_k            <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_taddr        <= '0;
            r_coeff_out    <= '0;
            r_coeff_addr   <= '0;
            r_coeff_valid  <= 1'b0;
            r_num_coeffs   <= '0;
            r_coeffs_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w          <= w_w_in;
                        r_transposed <= (tx_type != 4'd0);
                        r_dq         <= {1'b0, qindex} + 9'd4;
                        r_n          <= w_n_in;
                        r_state      <= S_READ_EOB;
                    end
                end

                S_READ_EOB: begin
                    if (symbol_valid) begin
                        r_eob        <= w_eob_in;
                        r_num_coeffs <= {{(16-NW){1'b0}}, w_eob_in};
                        r_k          <= '0;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_taddr      <= '0;
                        r_coeff_addr <= '0;
                        if (w_eob_in != '0) begin
                            r_state <= S_READ_LEVEL;
                        end else begin
                            r_coeff_out   <= '0;
                            r_coeff_valid <= 1'b1;
                            r_state       <= S_EMIT;
                        end
                    end
                end

                S_READ_LEVEL: begin
                    if (symbol_valid) begin
                        r_coeff_out   <= w_sat;
                        r_coeff_valid <= 1'b1;
                        r_state       <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (coeff_ready) begin
                        r_k          <= w_k_nxt;
                        r_col        <= w_col_nxt;
                        r_row        <= w_row_nxt;
                        r_taddr      <= w_taddr_nxt;
                        r_coeff_addr <= w_addr_nxt;
                        if (w_k_nxt < r_eob) begin
                            r_coeff_valid <= 1'b0;
                            r_state       <= S_READ_LEVEL;
                        end else if (w_k_nxt < r_n) begin
                            r_coeff_out <= '0;
                        end else begin
                            r_coeff_valid  <= 1'b0;
                            r_coeffs_valid <= 1'b1;
                            r_state        <= S_REPORT;
                        end
                    end
                end

                S_REPORT: begin
                    if (coeffs_ready) begin
                        r_coeffs_valid <= 1'b0;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign symbol_ready = (r_state == S_READ_EOB) || (r_state == S_READ_LEVEL);
    assign coeff_out    = r_coeff_out;
    assign coeff_addr   = r_coeff_addr;
    assign coeff_valid  = r_coeff_valid;
    assign num_coeffs   = r_num_coeffs;
    assign coeffs_valid = r_coeffs_valid;
    assign done         = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_av2_coeff_decoder.sv
// Directed bench for av2_coeff_decoder. Expected coefficients ({addr, value})
// are computed from the block parameters and pushed to exp_q when a block is
// started; a negedge monitor pops and compares on every coefficient transfer.
module tb_av2_coeff_decoder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] context_idx;
    logic [15:0] context_prob;
    logic [15:0] decoded_symbol;
    logic        symbol_valid;
    logic        symbol_ready;
    logic signed [15:0] coeff_out;
    logic [11:0] coeff_addr;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [15:0] num_coeffs;
    logic        coeffs_valid;
    logic        coeffs_ready;
    logic [5:0]  tx_size;
    logic [3:0]  tx_type;
    logic [7:0]  qindex;
    logic        start;
    logic        done;
    logic [2:0]  dbg_state;

    av2_coeff_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .context_idx   (context_idx),
        .context_prob  (context_prob),
        .decoded_symbol(decoded_symbol),
        .symbol_valid  (symbol_valid),
        .symbol_ready  (symbol_ready),
        .coeff_out     (coeff_out),
        .coeff_addr    (coeff_addr),
        .coeff_valid   (coeff_valid),
        .coeff_ready   (coeff_ready),
        .num_coeffs    (num_coeffs),
        .coeffs_valid  (coeffs_valid),
        .coeffs_ready  (coeffs_ready),
        .tx_size       (tx_size),
        .tx_type       (tx_type),
        .qindex        (qindex),
        .start         (start),
        .done          (done),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [27:0] exp_q[$];
    logic [15:0] lvl_q[$];
    int          exp_nc   = 0;
    int          done_cnt = 0;
    bit          bp_mode  = 1'b0;
    logic        ready_tie = 1'b1;
    bit          prev_stall = 1'b0;
    logic [11:0] prev_addr;
    logic [15:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] lvl, input int dq);
        int p;
        p = int'($signed(lvl)) * dq;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    // ---------------- coeff_ready driver ----------------
    // In bp_mode it behaves as a registered consumer: ready follows valid one
    // cycle later and drops after each accepted coefficient.
    initial begin
        logic nxt;
        coeff_ready = 1'b0;
        forever begin
            @(negedge clk);
            nxt = coeff_valid && !coeff_ready;
            @(posedge clk);
            #1;
            coeff_ready = bp_mode ? nxt : ready_tie;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (coeff_valid) chk("sym_ready_in_emit", {31'd0, symbol_ready}, 32'd0);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, coeff_valid}, 32'd1);
                chk("hold_addr", {20'd0, coeff_addr}, {20'd0, prev_addr});
                chk("hold_data", {16'd0, coeff_out}, {16'd0, prev_data});
            end
            prev_stall = coeff_valid && !coeff_ready;
            prev_addr  = coeff_addr;
            prev_data  = coeff_out;
            if (coeff_valid && coeff_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_coeff got addr=%0d data=%0d exp=none", coeff_addr, coeff_out);
                end
                if (exp_q.size() != 0) begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    chk("coeff_addr_data", {4'd0, coeff_addr, coeff_out}, {4'd0, e});
                end
            end
            if (coeffs_valid) chk("num_coeffs_report", {16'd0, num_coeffs}, exp_nc);
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_sym(input logic [15:0] s);
        int cyc;
        decoded_symbol = s;
        symbol_valid   = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!symbol_ready && cyc < 500);
        if (!symbol_ready) chk("symbol_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        symbol_valid   = 1'b0;
        decoded_symbol = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
        repeat (3) @(negedge clk);
        chk("done_one_pulse", done_cnt, 1);
        chk("idle_after_block", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Levels come from lvl_q; the expected stream is built before driving.
    task automatic run_block(input int ts, input int tt, input int qi, input int eob_sym);
        int w, n, eob, dq, addr;
        logic [15:0] d;
        w   = (ts < 4) ? 4 : ts;
        n   = w * w;
        dq  = qi + 4;
        eob = (eob_sym > n) ? n : eob_sym;
        exp_nc   = eob;
        done_cnt = 0;
        for (int k = 0; k < n; k++) begin
            addr = (tt == 0) ? k : (k % w) * w + k / w;
            d    = (k < eob) ? sat16(lvl_q[k], dq) : 16'h0000;
            exp_q.push_back({addr[11:0], d});
        end
        tx_size = ts[5:0];
        tx_type = tt[3:0];
        qindex  = qi[7:0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_sym(eob_sym[15:0]);
        for (int k = 0; k < eob; k++) send_sym(lvl_q[k]);
        wait_done();
        chk("queue_drained", exp_q.size(), 0);
        chk("num_coeffs_held", {16'd0, num_coeffs}, eob);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        rst_n          = 1'b0;
        context_idx    = 16'($urandom_range(0, 65535));
        context_prob   = 16'($urandom_range(0, 65535));
        decoded_symbol = 16'h0;
        symbol_valid   = 1'b0;
        coeffs_ready   = 1'b1;
        tx_size        = 6'd4;
        tx_type        = 4'd0;
        qindex         = 8'd0;
        start          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coeff_valid", {31'd0, coeff_valid}, 32'd0);
        chk("rst_symbol_ready", {31'd0, symbol_ready}, 32'd0);
        chk("rst_coeffs_valid", {31'd0, coeffs_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_num_coeffs", {16'd0, num_coeffs}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x4 raster, dq=4: levels 1,-2,5 -> 4,-8,20 then zero fill
        lvl_q = {16'd1, 16'hFFFE, 16'd5};
        run_block(4, 0, 0, 3);

        // transposed 4x4, dq=8: 7 -> addr0=56, 9 -> addr4=72
        lvl_q = {16'd7, 16'd9};
        run_block(4, 1, 4, 2);

        // saturation with dq=259
        lvl_q = {16'h7FFF, 16'h8000};
        run_block(4, 0, 255, 2);

        // transposed scan on a width that is not a power of two
        lvl_q.delete();
        for (int i = 0; i < 10; i++) lvl_q.push_back(16'($urandom_range(0, 65535)));
        run_block(6, 2, 3, 10);

        // tx_size below 4 floors to a 4x4 block
        lvl_q = {16'd2, 16'd3, 16'hFFFF, 16'd100};
        run_block(2, 0, 1, 4);

        // registered consumer: each coefficient held two cycles
        bp_mode = 1'b1;
        lvl_q.delete();
        for (int i = 0; i < 5; i++) lvl_q.push_back(16'($urandom_range(0, 65535)));
        run_block(4, 1, 10, 5);
        bp_mode = 1'b0;

        // eob=0 on an 8x8 block: 64 zeros
        lvl_q.delete();
        run_block(8, 0, 50, 0);

        // eob=100 clamps to 16 on a 4x4 block
        lvl_q.delete();
        for (int i = 0; i < 16; i++) lvl_q.push_back(16'($urandom_range(0, 65535)));
        run_block(4, 0, 20, 100);

        // reset while a coefficient is pending in EMIT
        ready_tie = 1'b0;
        @(posedge clk);
        #1;
        tx_size = 6'd4;
        tx_type = 4'd0;
        qindex  = 8'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_sym(16'd3);
        send_sym(16'd11);
        cyc = 0;
        while (!coeff_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("emit_reached", {31'd0, coeff_valid}, 32'd1);
        chk("emit_value", {16'd0, coeff_out}, 32'd44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_coeff_valid", {31'd0, coeff_valid}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_coeffs_valid", {31'd0, coeffs_valid}, 32'd0);
        chk("midrst_symbol_ready", {31'd0, symbol_ready}, 32'd0);
        chk("midrst_num_coeffs", {16'd0, num_coeffs}, 32'd0);
        chk("midrst_coeff_out", {16'd0, coeff_out}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ready_tie = 1'b1;
        @(negedge clk);
        chk("midrst_idle", {29'd0, dbg_state}, 32'd0);
        chk("midrst_ready_idle", {31'd0, symbol_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
